// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - note_sequencer control, song ROM and note output bundle
// master: sequencer side; slave: song ROM / player / control side.

interface note_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  i_start;
  logic                  i_stop;
  logic                  i_tick;
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic [15:0]           i_rom_data;
  logic                  o_load;
  logic [5:0]            o_pitch;
  logic [4:0]            o_duration;
  logic [3:0]            o_instrument;
  logic                  o_playing;
  logic                  o_song_end;

  modport master (
    input  i_start,
    input  i_stop,
    input  i_tick,
    input  i_rom_data,
    output o_rom_addr,
    output o_load,
    output o_pitch,
    output o_duration,
    output o_instrument,
    output o_playing,
    output o_song_end
  );

  modport slave (
    output i_start,
    output i_stop,
    output i_tick,
    output i_rom_data,
    input  o_rom_addr,
    input  o_load,
    input  o_pitch,
    input  o_duration,
    input  o_instrument,
    input  o_playing,
    input  o_song_end
  );
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song table walker feeding the note player, one note per tick window
// Optional NOTE_SEQUENCER_LOOP_EN: end marker rewinds to address 0 instead of stopping.

module note_sequencer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  note_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH_ADDR,
    FETCH_DATA,
    WAIT
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_d;
  logic [4:0]            count, count_d;
  logic [15:0]           pending, pending_d;
  logic                  load_d;
  logic                  song_end_d;
  logic                  playing_d;
  logic [5:0]            pitch_d;
  logic [4:0]            duration_d;
  logic [3:0]            instrument_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // The ROM address register is loaded on entry to FETCH_ADDR so the synchronous
  // ROM has its word ready by the FETCH_DATA sampling edge.
  always_comb begin
    state_d      = state;
    addr_d       = addr;
    count_d      = count;
    pending_d    = pending;
    rom_addr_d   = bus.o_rom_addr;
    load_d       = 1'b0;
    song_end_d   = 1'b0;
    playing_d    = bus.o_playing;
    pitch_d      = bus.o_pitch;
    duration_d   = bus.o_duration;
    instrument_d = bus.o_instrument;

    if (bus.i_stop) begin
      state_d   = IDLE;
      playing_d = 1'b0;
    end else if (bus.i_start) begin
      state_d    = FETCH_ADDR;
      addr_d     = '0;
      count_d    = '0;
      rom_addr_d = '0;
      playing_d  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_d = IDLE;
        end
        FETCH_ADDR: begin
          state_d = FETCH_DATA;
        end
        FETCH_DATA: begin
          pending_d = bus.i_rom_data;
          state_d   = WAIT;
        end
        WAIT: begin
          if (bus.i_tick) begin
            if (count != 5'd0) begin
              count_d = count - 5'd1;
            end else if (pending[15]) begin
              song_end_d = 1'b1;
`ifdef NOTE_SEQUENCER_LOOP_EN
              addr_d     = '0;
              rom_addr_d = '0;
              state_d    = FETCH_ADDR;
`else
              state_d    = IDLE;
              playing_d  = 1'b0;
`endif
            end else begin
              load_d       = 1'b1;
              pitch_d      = pending[14:9];
              duration_d   = pending[8:4];
              instrument_d = pending[3:0];
              count_d      = pending[8:4];
              addr_d       = addr + 1'b1;
              rom_addr_d   = addr + 1'b1;
              state_d      = FETCH_ADDR;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr             <= '0;
      count            <= '0;
      pending          <= '0;
      bus.o_rom_addr   <= '0;
      bus.o_load       <= 1'b0;
      bus.o_song_end   <= 1'b0;
      bus.o_playing    <= 1'b0;
      bus.o_pitch      <= '0;
      bus.o_duration   <= '0;
      bus.o_instrument <= '0;
    end else begin
      addr             <= addr_d;
      count            <= count_d;
      pending          <= pending_d;
      bus.o_rom_addr   <= rom_addr_d;
      bus.o_load       <= load_d;
      bus.o_song_end   <= song_end_d;
      bus.o_playing    <= playing_d;
      bus.o_pitch      <= pitch_d;
      bus.o_duration   <= duration_d;
      bus.o_instrument <= instrument_d;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer with a 4-entry song ROM
// Expected strobes are queued by the stimulus and consumed by a negedge monitor.

module tb_note_sequencer;

  localparam int AW = 2;

  logic clk;
  logic rst;

  note_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  note_sequencer #(.ADDR_WIDTH(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       load;
    logic       song_end;
    logic [5:0] pitch;
    logic [4:0] dur;
    logic [3:0] inst;
    logic       playing;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rom [4];
  int          n_vec;
  int          n_miss;

`ifdef NOTE_SEQUENCER_LOOP_EN
  localparam logic END_PLAYING = 1'b1;
`else
  localparam logic END_PLAYING = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];

  always @(negedge clk) begin
    if (!rst && (bus.o_load || bus.o_song_end)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_strobe: got load=%0b end=%0b pitch=%0d, required none",
                 bus.o_load, bus.o_song_end, bus.o_pitch);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.o_load !== e.load || bus.o_song_end !== e.song_end ||
            bus.o_playing !== e.playing ||
            (e.load && {bus.o_pitch, bus.o_duration, bus.o_instrument} !== {e.pitch, e.dur, e.inst})) begin
          n_miss++;
          $display("FAIL strobe: got load=%0b end=%0b p=%0d d=%0d i=%0d play=%0b, required load=%0b end=%0b p=%0d d=%0d i=%0d play=%0b",
                   bus.o_load, bus.o_song_end, bus.o_pitch, bus.o_duration, bus.o_instrument, bus.o_playing,
                   e.load, e.song_end, e.pitch, e.dur, e.inst, e.playing);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_load(input logic [5:0] p, input logic [4:0] d, input logic [3:0] i);
    exp_t e;
    e = '{load: 1'b1, song_end: 1'b0, pitch: p, dur: d, inst: i, playing: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic push_end();
    exp_t e;
    e = '{load: 1'b0, song_end: 1'b1, pitch: 6'd0, dur: 5'd0, inst: 4'd0, playing: END_PLAYING};
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    cyc(1);
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.i_stop = 1'b1;
    cyc(1);
    bus.i_stop = 1'b0;
  endtask

  task automatic tick_edge();
    bus.i_tick = 1'b1;
    cyc(1);
    bus.i_tick = 1'b0;
  endtask

  task automatic do_tick();
    tick_edge();
    cyc(7);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_addr"}, 16'(bus.o_rom_addr), 16'd0);
    chk({tag, "_load"}, 16'(bus.o_load), 16'd0);
    chk({tag, "_pitch"}, 16'(bus.o_pitch), 16'd0);
    chk({tag, "_duration"}, 16'(bus.o_duration), 16'd0);
    chk({tag, "_instrument"}, 16'(bus.o_instrument), 16'd0);
    chk({tag, "_playing"}, 16'(bus.o_playing), 16'd0);
    chk({tag, "_song_end"}, 16'(bus.o_song_end), 16'd0);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    bus.i_tick = 1'b0;
    rom[0] = 16'h1423;
    rom[1] = 16'h2801;
    rom[2] = 16'h8000;
    rom[3] = 16'h0000;
    cyc(2);
    chk_all_zero("reset");
    rst = 1'b0;
    cyc(2);

    // Song (10,2,3) (20,0,1) END, ticks every 8 cycles
    pulse_start();
    chk("start_playing", 16'(bus.o_playing), 16'd1);
    chk("start_rom_addr", 16'(bus.o_rom_addr), 16'd0);
    cyc(3);
    push_load(6'd10, 5'd2, 4'd3);
    do_tick();
    do_tick();
    do_tick();
    push_load(6'd20, 5'd0, 4'd1);
    do_tick();
    push_end();
    do_tick();
    chk("after_end_playing", 16'(bus.o_playing), 16'(END_PLAYING));
`ifdef NOTE_SEQUENCER_LOOP_EN
    push_load(6'd10, 5'd2, 4'd3);
`endif
    do_tick();
    pulse_stop();
    chk("hold_pitch_after_song", 16'(bus.o_pitch), 16'd10 + 16'(!END_PLAYING) * 16'd10);
    cyc(2);

    // Stop one cycle after the first load
    pulse_start();
    cyc(3);
    push_load(6'd10, 5'd2, 4'd3);
    tick_edge();
    cyc(1);
    pulse_stop();
    chk("stop_playing", 16'(bus.o_playing), 16'd0);
    chk("stop_pitch_held", 16'(bus.o_pitch), 16'd10);
    chk("stop_rom_addr", 16'(bus.o_rom_addr), 16'd1);
    do_tick();
    do_tick();
    do_tick();
    pulse_start();
    chk("restart_rom_addr", 16'(bus.o_rom_addr), 16'd0);
    cyc(3);
    pulse_stop();
    cyc(2);

    // Empty song
    rom[0] = 16'h8000;
    pulse_start();
    cyc(3);
    push_end();
    do_tick();
`ifdef NOTE_SEQUENCER_LOOP_EN
    push_end();
`endif
    do_tick();
    chk("empty_load_low", 16'(bus.o_load), 16'd0);
    pulse_stop();
    cyc(2);

    // Four notes, no end marker: address wraps 0,1,2,3,0
    rom[0] = 16'h0A01;
    rom[1] = 16'h0C02;
    rom[2] = 16'h0E03;
    rom[3] = 16'h1004;
    pulse_start();
    chk("wrap_rom_addr_0", 16'(bus.o_rom_addr), 16'd0);
    cyc(3);
    for (int k = 0; k < 5; k++) begin
      push_load(6'd5 + 6'(k % 4), 5'd0, 4'd1 + 4'(k % 4));
      tick_edge();
      chk($sformatf("wrap_rom_addr_%0d", k + 1), 16'(bus.o_rom_addr), 16'((k + 1) % 4));
      cyc(7);
    end
    pulse_stop();
    cyc(2);

    // Simultaneous start and stop from IDLE
    bus.i_start = 1'b1;
    bus.i_stop = 1'b1;
    cyc(1);
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    chk("start_stop_playing", 16'(bus.o_playing), 16'd0);
    chk("start_stop_rom_addr", 16'(bus.o_rom_addr), 16'd1);
    cyc(3);
    do_tick();
    chk("start_stop_still_idle", 16'(bus.o_playing), 16'd0);

    // Asynchronous reset mid-song
    pulse_start();
    cyc(3);
    push_load(6'd5, 5'd0, 4'd1);
    do_tick();
    chk("pre_reset_pitch", 16'(bus.o_pitch), 16'd5);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    cyc(2);
    rst = 1'b0;
    cyc(3);
    do_tick();
    do_tick();
    chk("post_reset_playing", 16'(bus.o_playing), 16'd0);

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
